mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the MIPS-R2000 pipeline, directly downstream of EX.
- Consumes EX/MEM register contents (res, write_data_ex, write_register_ex, m_MEM, wb_MEM, zero) and drives a req/ack data-memory port.
- Produces the MEM/WB pipeline register, branch resolution (pc_src) and a stall request that freezes IF/ID/EX while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max REQ cycles waiting for mem_ack before the access is abandoned with bus_err.
- AW, 32, data-memory address width (low AW bits of res).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- res  in  32  ALU result from EX/MEM; memory address or passthrough value
- zero  in  1  ALU zero flag from EX/MEM
- write_data_ex  in  32  store data (forwarded rt)
- write_register_ex  in  5  destination register
- m_MEM  in  3  [2]=branch, [1]=mem_read, [0]=mem_write
- wb_MEM  in  2  [1]=reg_write, [0]=mem_to_reg
- mem_rdata  in  32  read data from data memory, valid with mem_ack
- mem_ack  in  1  memory completion strobe, one cycle
- mem_req  out  1  registered access request
- mem_we  out  1  registered write enable, qualifies mem_req
- mem_addr  out  AW  registered word address
- mem_wdata  out  32  registered store data
- stall_mem  out  1  combinational; 1 = upstream stages and EX/MEM register hold
- pc_src  out  1  combinational, m_MEM[2] & zero
- addr_err  out  1  registered, pulses 1 cycle on misaligned access
- bus_err  out  1  registered, pulses 1 cycle on timeout
- read_data_wb  out  32  MEM/WB: loaded data
- res_wb  out  32  MEM/WB: ALU result passthrough
- rd_WB  out  5  MEM/WB: destination register
- wb_WB  out  2  MEM/WB: reg_write, mem_to_reg

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset outputs: state=IDLE; mem_req, mem_we, addr_err, bus_err=0; mem_addr, mem_wdata=0; all MEM/WB outputs=0; timeout counter=0.
- Access: access = m_MEM[1] | m_MEM[0]. If both bits are set, treat as a read.
- Alignment: misaligned = access & (res[1:0]!=0).
- State IDLE:
  - no access: stall_mem=0; MEM/WB loads the passthrough (res_wb=res, rd_WB=write_register_ex, wb_WB=wb_MEM, read_data_wb=0). Latency 1 cycle.
  - misaligned: no request issued; stall_mem=0; addr_err<=1; MEM/WB loads with wb_WB forced to 0.
  - aligned access: stall_mem=1; mem_req<=1; mem_we<=m_MEM[0]&~m_MEM[1]; mem_addr<=res; mem_wdata<=write_data_ex; counter<=0; go to REQ.
- State REQ: stall_mem=1; mem_req, mem_we, mem_addr, mem_wdata held.
  - mem_ack=1: capture mem_rdata into an internal buffer; mem_req<=0, mem_we<=0; go to DONE.
  - else if counter==TIMEOUT-1: mem_req<=0, mem_we<=0; bus_err<=1; buffer<=0; set abort flag; go to DONE.
  - else counter<=counter+1.
  - mem_ack outside REQ is ignored.
- State DONE: stall_mem=0; MEM/WB loads read_data_wb=buffer, res_wb=res, rd_WB=write_register_ex, wb_WB=wb_MEM (forced to 0 if abort); clear abort; go to IDLE.
- Access latency: IDLE cycle + k REQ cycles (ack sampled in the k-th) + DONE cycle = k+2 cycles; minimum 3.
- Holding: while stall_mem=1, MEM/WB outputs hold their previous values and inputs are required to be stable (upstream frozen).
- Back-to-back accesses: the next instruction is evaluated in the IDLE cycle directly after DONE. There is no idle bubble beyond the stall.
- pc_src: purely combinational; valid in every state; not gated by stall.
- Error flags: addr_err and bus_err are single-cycle pulses, cleared the next cycle unless re-asserted.
- Reset mid-operation: rst in REQ or DONE returns to IDLE next edge. mem_req drops that edge; the pending transaction is discarded and later acks are ignored.

Test Plan:
- Passthrough: res=0x0000_0010, wb_MEM=2'b10, write_register_ex=5, m_MEM=0 -> next edge res_wb=0x10, rd_WB=5, wb_WB=2'b10; stall_mem=0 throughout.
- Load, immediate ack: m_MEM=3'b010, res=0x100, mem_ack=1 in the first REQ cycle with mem_rdata=0xDEADBEEF -> mem_req high exactly 1 cycle with mem_addr=0x100, mem_we=0; stall_mem=1 for 2 cycles; read_data_wb=0xDEADBEEF on the 3rd edge.
- Store, ack after 3 REQ cycles: m_MEM=3'b001, write_data_ex=0x1234 -> mem_we=1, mem_wdata=0x1234 for 3 cycles; stall 4 cycles; wb_WB equals input wb_MEM.
- Timeout: load with no ack, TIMEOUT=16 -> mem_req high 16 cycles; bus_err pulses once; wb_WB=0 after DONE.
- Misaligned load: res=0x102, m_MEM=3'b010 -> no mem_req; addr_err=1 for 1 cycle; wb_WB=0; no stall.
- Reset in REQ, plus branch: rst asserted in the 2nd REQ cycle -> all outputs 0 next edge; a late mem_ack is ignored. m_MEM[2]=1 with zero=1 -> pc_src=1 in the same cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
  parameter int unsigned AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS-R2000 memory-access stage: drives the data-memory req/ack port, produces the
// MEM/WB register, branch select and a stall that freezes upstream during an access.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned AW      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] res,
  input  logic        zero,
  input  logic [31:0] write_data_ex,
  input  logic [4:0]  write_register_ex,
  input  logic [2:0]  m_MEM,
  input  logic [1:0]  wb_MEM,
  mem_stage_if.master mem,
  output logic        stall_mem,
  output logic        pc_src,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] read_data_wb,
  output logic [31:0] res_wb,
  output logic [4:0]  rd_WB,
  output logic [1:0]  wb_WB
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     buf_q, buf_d;
  logic            abort_q, abort_d;
  logic            addr_err_q, addr_err_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     rdata_wb_q, rdata_wb_d;
  logic [31:0]     res_wb_q, res_wb_d;
  logic [4:0]      rd_wb_q, rd_wb_d;
  logic [1:0]      wb_wb_q, wb_wb_d;

  logic access, misaligned;

  assign access     = m_MEM[1] | m_MEM[0];
  assign misaligned = access & (res[1:0] != 2'b00);
  assign pc_src     = m_MEM[2] & zero;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    abort_d    = abort_q;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    rdata_wb_d = rdata_wb_q;
    res_wb_d   = res_wb_q;
    rd_wb_d    = rd_wb_q;
    wb_wb_d    = wb_wb_q;
    stall_mem  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access && !misaligned) begin
          stall_mem = 1'b1;
          req_d     = 1'b1;
          // Read wins when both read and write are flagged.
          we_d      = m_MEM[0] & ~m_MEM[1];
          addr_d    = res[AW-1:0];
          wdata_d   = write_data_ex;
          cnt_d     = '0;
          state_d   = StReq;
        end else begin
          rdata_wb_d = 32'h0;
          res_wb_d   = res;
          rd_wb_d    = write_register_ex;
          wb_wb_d    = misaligned ? 2'b00 : wb_MEM;
          addr_err_d = misaligned;
        end
      end
      StReq: begin
        stall_mem = 1'b1;
        if (mem.mem_ack) begin
          buf_d   = mem.mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
          buf_d     = 32'h0;
          abort_d   = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        rdata_wb_d = buf_q;
        res_wb_d   = res;
        rd_wb_d    = write_register_ex;
        wb_wb_d    = abort_q ? 2'b00 : wb_MEM;
        abort_d    = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
      abort_q    <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_wb_q <= 32'h0;
      res_wb_q   <= 32'h0;
      rd_wb_q    <= 5'h0;
      wb_wb_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      abort_q    <= abort_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
      rdata_wb_q <= rdata_wb_d;
      res_wb_q   <= res_wb_d;
      rd_wb_q    <= rd_wb_d;
      wb_wb_q    <= wb_wb_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign addr_err      = addr_err_q;
  assign bus_err       = bus_err_q;
  assign read_data_wb  = rdata_wb_q;
  assign res_wb        = res_wb_q;
  assign rd_WB         = rd_wb_q;
  assign wb_WB         = wb_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, load, store, timeout, misaligned, reset, branch.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] res;
  logic        zero;
  logic [31:0] write_data_ex;
  logic [4:0]  write_register_ex;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        stall_mem;
  logic        pc_src;
  logic        addr_err;
  logic        bus_err;
  logic [31:0] read_data_wb;
  logic [31:0] res_wb;
  logic [4:0]  rd_WB;
  logic [1:0]  wb_WB;

  int n_vec = 0;
  int n_err = 0;
  int req_cycles;
  int err_pulses;

  mem_stage_if #(.AW(32)) mem_bus ();

  mem_stage #(
    .TIMEOUT(16),
    .AW     (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .res              (res),
    .zero             (zero),
    .write_data_ex    (write_data_ex),
    .write_register_ex(write_register_ex),
    .m_MEM            (m_MEM),
    .wb_MEM           (wb_MEM),
    .mem              (mem_bus),
    .stall_mem        (stall_mem),
    .pc_src           (pc_src),
    .addr_err         (addr_err),
    .bus_err          (bus_err),
    .read_data_wb     (read_data_wb),
    .res_wb           (res_wb),
    .rd_WB            (rd_WB),
    .wb_WB            (wb_WB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; res = '0; zero = 1'b0; write_data_ex = '0; write_register_ex = '0;
    m_MEM = '0; wb_MEM = '0; mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    tick();
    tick();
    chk("rst_req", {31'h0, mem_bus.mem_req}, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_res_wb", res_wb, 0);
    chk("rst_wb", {30'h0, wb_WB}, 0);
    chk("rst_stall", {31'h0, stall_mem}, 0);
    chk("rst_errs", {30'h0, addr_err, bus_err}, 0);
    rst = 1'b0;

    // Passthrough
    res = 32'h10; wb_MEM = 2'b10; write_register_ex = 5'd5; m_MEM = 3'b000;
    #2 chk("pt_stall", {31'h0, stall_mem}, 0);
    tick();
    chk("pt_res_wb", res_wb, 32'h10);
    chk("pt_rd", {27'h0, rd_WB}, 5);
    chk("pt_wb", {30'h0, wb_WB}, 2'b10);
    chk("pt_rdata", read_data_wb, 0);

    // Load with ack in first REQ cycle
    m_MEM = 3'b010; res = 32'h100; wb_MEM = 2'b11; write_register_ex = 5'd7;
    #2 chk("ld_stall_idle", {31'h0, stall_mem}, 1);
    tick();
    chk("ld_req", {31'h0, mem_bus.mem_req}, 1);
    chk("ld_addr", mem_bus.mem_addr, 32'h100);
    chk("ld_we", {31'h0, mem_bus.mem_we}, 0);
    chk("ld_stall_req", {31'h0, stall_mem}, 1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEADBEEF;
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    chk("ld_req_drop", {31'h0, mem_bus.mem_req}, 0);
    chk("ld_stall_done", {31'h0, stall_mem}, 0);
    chk("ld_hold", read_data_wb, 0);
    tick();
    m_MEM = 3'b000;
    chk("ld_rdata", read_data_wb, 32'hDEADBEEF);
    chk("ld_res_wb", res_wb, 32'h100);
    chk("ld_wb", {30'h0, wb_WB}, 2'b11);
    chk("ld_rd", {27'h0, rd_WB}, 7);

    // Store acked in third REQ cycle
    m_MEM = 3'b001; res = 32'h200; write_data_ex = 32'h1234; wb_MEM = 2'b10;
    write_register_ex = 5'd9;
    tick();
    chk("st_we0", {31'h0, mem_bus.mem_we}, 1);
    chk("st_wdata", mem_bus.mem_wdata, 32'h1234);
    tick();
    chk("st_we1", {31'h0, mem_bus.mem_we}, 1);
    chk("st_stall1", {31'h0, stall_mem}, 1);
    tick();
    chk("st_we2", {31'h0, mem_bus.mem_we}, 1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h5555;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("st_req_drop", {31'h0, mem_bus.mem_req}, 0);
    chk("st_we_drop", {31'h0, mem_bus.mem_we}, 0);
    chk("st_stall_done", {31'h0, stall_mem}, 0);
    tick();
    m_MEM = 3'b000;
    chk("st_wb", {30'h0, wb_WB}, 2'b10);
    chk("st_res_wb", res_wb, 32'h200);
    chk("st_rd", {27'h0, rd_WB}, 9);

    // Timeout: load with no ack
    m_MEM = 3'b010; res = 32'h300; wb_MEM = 2'b11; write_register_ex = 5'd3;
    req_cycles = 0; err_pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_bus.mem_req) req_cycles++;
      if (bus_err) err_pulses++;
      if (!mem_bus.mem_req) break;
    end
    chk("to_req_cycles", req_cycles, 16);
    chk("to_bus_err", err_pulses, 1);
    tick();
    m_MEM = 3'b000;
    chk("to_bus_err_clr", {31'h0, bus_err}, 0);
    chk("to_wb", {30'h0, wb_WB}, 0);
    chk("to_rdata", read_data_wb, 0);
    chk("to_res_wb", res_wb, 32'h300);

    // Misaligned load
    m_MEM = 3'b010; res = 32'h102; wb_MEM = 2'b11; write_register_ex = 5'd4;
    #2 chk("ma_stall", {31'h0, stall_mem}, 0);
    tick();
    m_MEM = 3'b000;
    chk("ma_req", {31'h0, mem_bus.mem_req}, 0);
    chk("ma_addr_err", {31'h0, addr_err}, 1);
    chk("ma_wb", {30'h0, wb_WB}, 0);
    chk("ma_res_wb", res_wb, 32'h102);
    tick();
    chk("ma_addr_err_clr", {31'h0, addr_err}, 0);

    // Reset during second REQ cycle, then a late ack
    m_MEM = 3'b010; res = 32'h400; wb_MEM = 2'b11; write_register_ex = 5'd6;
    tick();
    tick();
    chk("rr_req", {31'h0, mem_bus.mem_req}, 1);
    rst = 1'b1; m_MEM = 3'b000; res = 32'h0; wb_MEM = 2'b00; write_register_ex = 5'd0;
    tick();
    rst = 1'b0;
    chk("rr_req_drop", {31'h0, mem_bus.mem_req}, 0);
    chk("rr_addr", mem_bus.mem_addr, 0);
    chk("rr_res_wb", res_wb, 0);
    chk("rr_rd", {27'h0, rd_WB}, 0);
    chk("rr_stall", {31'h0, stall_mem}, 0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("rr_late_ack_req", {31'h0, mem_bus.mem_req}, 0);
    chk("rr_late_ack_rdata", read_data_wb, 0);
    tick();
    chk("rr_late_ack_rdata2", read_data_wb, 0);

    // Branch resolution
    m_MEM = 3'b100; zero = 1'b1;
    #1 chk("br_taken", {31'h0, pc_src}, 1);
    zero = 1'b0;
    #1 chk("br_not_taken", {31'h0, pc_src}, 0);
    m_MEM = 3'b000; zero = 1'b1;
    #1 chk("br_no_branch", {31'h0, pc_src}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
